rupt_controller: RTL and testbench
==================================

// Module: rupt_controller
// PURPOSE
//  Interrupt (RUPT) sequencer for the pipelined AGC core. Edge-detects the rupt sources (T6, T5, T3, T4,
//  KEYRUPT1/2, UPRUPT, DOWNRUPT, RADAR, HANDRUPT) and latches each as pending. Selects the highest-priority
//  eligible source and presents its vector to the core fetch path as a req/ack handshake.
//  Blocks further grants until the ISR's RESUME retires. Honours INHINT/RELINT and the A-register overflow lockout.
// PARAMETERS
//  NUM_RUPT       10       number of rupt sources; index 0 = highest priority
//  VECTOR_BASE    'o4000   12-bit fixed-memory base of the vector table
//  VECTOR_STRIDE  4        words per vector slot
// PORTS
//  clock          in   1         core clock; all state updates on posedge
//  rst_l          in   1         asynchronous, active-low reset
//  rupt_src       in   NUM_RUPT  source levels, synchronous to clock; rising edge = event
//  inhibit_set    in   1         INHINT retired (1-cycle pulse)
//  inhibit_clr    in   1         RELINT retired (1-cycle pulse)
//  ovf_lock       in   1         A holds overflow; grants blocked while high
//  rupt_ack       in   1         core has redirected fetch to rupt_vector (1-cycle pulse)
//  resume         in   1         RESUME retired (1-cycle pulse)
//  rupt_req       out  1         vector valid, core must take at next instruction boundary
//  rupt_vector    out  12        vector address, stable while rupt_req
//  rupt_idx       out  4         index of the source being requested or serviced
//  in_isr         out  1         ISR active (ack seen, resume not yet seen)
//  inhibited      out  1         INHINT state
//  pending        out  NUM_RUPT  latched, unserviced events
// BEHAVIOUR
//  Reset: state IDLE. All of rupt_req, rupt_vector, rupt_idx, in_isr, inhibited and pending are 0.
//    Edge-detect history is 0. Reset mid-handshake discards everything with no partial ack.
//  Edge detect: prev <= rupt_src each cycle. pending[i] sets on rupt_src[i] & ~prev[i].
//    A source held high gives exactly one event.
//  Pending clear: bit rupt_idx clears on the cycle rupt_ack is accepted.
//    If a new edge on the same source arrives in that cycle, the set wins and the bit stays 1.
//  inhibited: set by inhibit_set, cleared by inhibit_clr. If both pulse in the same cycle, set wins.
//  eligible = (pending != 0) & ~inhibited & ~ovf_lock.
//  Winner = lowest set index of pending (fixed priority).
//  FSM:
//    IDLE -> REQ when eligible. rupt_idx and rupt_vector are registered on that transition.
//    REQ: rupt_req = 1. rupt_idx and rupt_vector stay frozen; a later higher-priority edge does not preempt.
//      REQ -> ISR on rupt_ack: clear pending[rupt_idx], in_isr <= 1, rupt_req <= 0.
//      REQ -> IDLE if inhibited or ovf_lock rises before ack. The request is withdrawn, pending is kept,
//        and it is re-arbitrated later. If ack and the withdraw condition occur in the same cycle, ack wins.
//    ISR: rupt_req = 0, in_isr = 1. New edges still latch into pending; nothing is granted (no nesting).
//      ISR -> IDLE on resume, in_isr <= 0. The next grant can be requested 1 cycle later.
//  Ignored inputs: rupt_ack outside REQ; resume outside ISR.
//  Vector: VECTOR_BASE + VECTOR_STRIDE*(idx+1), 12-bit, wraps modulo 4096 (slot 'o4000 = GOJAM).
//  Latency: edge sampled at posedge N -> pending at N+1 -> rupt_req at N+2 (when eligible and IDLE).
//  rupt_idx: holds its last value in IDLE. Source indices >= NUM_RUPT never occur.
// TESTING
//  1. Reset, then pulse rupt_src[0] (T6) -> pending[0] 1 cycle later; rupt_req=1 with rupt_vector='o4004 and
//     rupt_idx=0 two cycles later. ack -> pending=0, in_isr=1. resume -> in_isr=0, state IDLE.
//  2. Edges on src[4] and src[2] in the same cycle -> idx 2 granted, vector 'o4014.
//     After resume, idx 4 granted with vector 'o4024.
//  3. Set inhibited, then raise src[1] -> pending[1]=1 and rupt_req stays 0.
//     inhibit_clr -> rupt_req=1 two cycles later with vector 'o4010.
//  4. In REQ for idx 3, raise ovf_lock -> rupt_req drops next cycle and pending[3] is kept.
//     Drop ovf_lock -> request reissued.
//  5. In ISR, raise src[0] -> pending[0] latches but no req. resume -> idx 0 requested 2 cycles later.
//     An edge on src[3] in the ack cycle for idx 3 leaves pending[3]=1.
//  6. Assert rst_l=0 while REQ and while ISR -> all outputs 0 asynchronously.
//     rupt_src held high through reset release produces one event.

Source files
------------

// File: rtl/rupt_if.sv
// rupt_if: handshake between the core (master) and the rupt sequencer (slave)
interface rupt_if #(parameter int NUM_RUPT = 10);
  logic [NUM_RUPT-1:0] rupt_src;
  logic                inhibit_set;
  logic                inhibit_clr;
  logic                ovf_lock;
  logic                rupt_ack;
  logic                resume;
  logic                rupt_req;
  logic [11:0]         rupt_vector;
  logic [3:0]          rupt_idx;
  logic                in_isr;
  logic                inhibited;
  logic [NUM_RUPT-1:0] pending;
  modport master (
    output rupt_src, inhibit_set, inhibit_clr, ovf_lock, rupt_ack, resume,
    input  rupt_req, rupt_vector, rupt_idx, in_isr, inhibited, pending
  );
  modport slave (
    input  rupt_src, inhibit_set, inhibit_clr, ovf_lock, rupt_ack, resume,
    output rupt_req, rupt_vector, rupt_idx, in_isr, inhibited, pending
  );
endinterface

// File: rtl/rupt_controller.sv
// rupt_controller: edge-latched, fixed-priority interrupt sequencer with req/ack/resume handshake
module rupt_controller #(
  parameter int          NUM_RUPT      = 10,
  parameter logic [11:0] VECTOR_BASE   = 12'o4000,
  parameter int          VECTOR_STRIDE = 4
) (
  input logic   clock,
  input logic   rst_l,
  rupt_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, ISR} state_t;
  state_t              state, state_nxt;
  logic [NUM_RUPT-1:0] prev, pending, edges, clr_mask;
  logic                inhibited, eligible, ack, withdraw;
  logic [3:0]          idx, win;
  logic [11:0]         vector;
  assign edges    = bus.rupt_src & ~prev;
  assign eligible = |pending & ~inhibited & ~bus.ovf_lock;
  assign ack      = state == REQ && bus.rupt_ack;
  assign withdraw = inhibited | bus.ovf_lock;
  assign clr_mask = ack ? NUM_RUPT'(1) << idx : '0;
  // Descending scan so the lowest pending index is the last one written.
  always_comb begin
    win = '0;
    for (int i = NUM_RUPT - 1; i >= 0; i--) if (pending[i]) win = 4'(i);
  end
  always_ff @(posedge clock or negedge rst_l)
    if (!rst_l) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (eligible ? REQ : IDLE) :
                state == REQ  ? (bus.rupt_ack ? ISR : withdraw ? IDLE : REQ) :
                state == ISR  ? (bus.resume ? IDLE : ISR) : IDLE;
  end
  always_comb begin
    bus.rupt_req = state == REQ;
    bus.in_isr   = state == ISR;
  end
  // A same-cycle edge re-sets a bit cleared by ack, so the set wins.
  always_ff @(posedge clock or negedge rst_l)
    if (!rst_l) begin
      prev      <= '0;
      pending   <= '0;
      inhibited <= 1'b0;
      idx       <= '0;
      vector    <= '0;
    end else begin
      prev      <= bus.rupt_src;
      pending   <= (pending & ~clr_mask) | edges;
      inhibited <= bus.inhibit_set | (inhibited & ~bus.inhibit_clr);
      if (state == IDLE && eligible) begin
        idx    <= win;
        vector <= VECTOR_BASE + 12'(VECTOR_STRIDE * (int'(win) + 1));
      end
    end
  assign bus.rupt_idx    = idx;
  assign bus.rupt_vector = vector;
  assign bus.inhibited   = inhibited;
  assign bus.pending     = pending;
endmodule

// File: tb/tb_rupt_controller.sv
// tb_rupt_controller: directed vector table, reset corner sequences and randomized run against a reference model
module tb_rupt_controller;
  logic clock = 1'b0;
  logic rst_l = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  rupt_if #(.NUM_RUPT(10)) bus ();
  rupt_controller #(.NUM_RUPT(10)) dut (.clock(clock), .rst_l(rst_l), .bus(bus));
  always #5 clock = ~clock;
  typedef struct packed {
    logic [9:0]  src;
    logic        set, clr, ovf, ack, res;
    logic        req;
    logic [11:0] vec;
    logic [3:0]  idx;
    logic        isr, inh;
    logic [9:0]  pend;
  } row_t;
  row_t tbl[36];
  function automatic row_t r(input logic [9:0] src, input logic set, clr, ovf, ack, res,
                             input logic req, input logic [11:0] vec, input logic [3:0] idx,
                             input logic isr, inh, input logic [9:0] pend);
    return '{src, set, clr, ovf, ack, res, req, vec, idx, isr, inh, pend};
  endfunction
  task automatic drive(input logic [9:0] src, input logic set, clr, ovf, ack, res);
    bus.rupt_src = src; bus.inhibit_set = set; bus.inhibit_clr = clr;
    bus.ovf_lock = ovf; bus.rupt_ack = ack; bus.resume = res;
  endtask
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string name, input logic [28:0] exp);
    logic [28:0] got;
    got = {bus.rupt_req, bus.rupt_vector, bus.rupt_idx, bus.in_isr, bus.inhibited, bus.pending};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got req=%b vec=%o idx=%0d isr=%b inh=%b pend=%b, expected req=%b vec=%o idx=%0d isr=%b inh=%b pend=%b",
               name, got[28], got[27:16], got[15:12], got[11], got[10], got[9:0],
               exp[28], exp[27:16], exp[15:12], exp[11], exp[10], exp[9:0]);
    end
  endtask
  task automatic do_reset();
    drive('0, 0, 0, 0, 0, 0);
    rst_l = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_l = 1'b1;
  endtask
  // Reference model: pending set as a bit vector, handshake phase as two flags.
  logic [9:0] m_prev, m_pend;
  logic       m_inh, m_req, m_isr;
  int         m_idx, m_vec;
  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_inh = 0; m_req = 0; m_isr = 0; m_idx = 0; m_vec = 0;
  endtask
  task automatic model_step(input logic [9:0] src, input logic set, clr, ovf, ack, res);
    int w = -1;
    int cleared = -1;
    for (int i = 9; i >= 0; i--) if (m_pend[i]) w = i;
    if (m_req) begin
      if (ack) begin m_req = 0; m_isr = 1; cleared = m_idx; end
      else if (m_inh || ovf) m_req = 0;
    end else if (m_isr) begin
      if (res) m_isr = 0;
    end else if (w >= 0 && !m_inh && !ovf) begin
      m_req = 1; m_idx = w; m_vec = ('o4000 + 4 * (w + 1)) % 4096;
    end
    for (int i = 0; i < 10; i++) m_pend[i] = (m_pend[i] && i != cleared) || (src[i] && !m_prev[i]);
    m_inh = set || (m_inh && !clr);
    m_prev = src;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [9:0] src;
    logic       set, clr, ovf, ack, res;
    tbl[0]  = r(10'h001, 0,0,0,0,0, 0,12'o0000,0,0,0,10'h001);
    tbl[1]  = r(10'h000, 0,0,0,0,0, 1,12'o4004,0,0,0,10'h001);
    tbl[2]  = r(10'h000, 0,0,0,0,0, 1,12'o4004,0,0,0,10'h001);
    tbl[3]  = r(10'h000, 0,0,0,1,0, 0,12'o4004,0,1,0,10'h000);
    tbl[4]  = r(10'h000, 0,0,0,0,0, 0,12'o4004,0,1,0,10'h000);
    tbl[5]  = r(10'h000, 0,0,0,0,1, 0,12'o4004,0,0,0,10'h000);
    tbl[6]  = r(10'h014, 0,0,0,0,0, 0,12'o4004,0,0,0,10'h014);
    tbl[7]  = r(10'h000, 0,0,0,0,0, 1,12'o4014,2,0,0,10'h014);
    tbl[8]  = r(10'h000, 0,0,0,1,0, 0,12'o4014,2,1,0,10'h010);
    tbl[9]  = r(10'h000, 0,0,0,0,1, 0,12'o4014,2,0,0,10'h010);
    tbl[10] = r(10'h000, 0,0,0,0,0, 1,12'o4024,4,0,0,10'h010);
    tbl[11] = r(10'h000, 0,0,0,1,0, 0,12'o4024,4,1,0,10'h000);
    tbl[12] = r(10'h000, 0,0,0,0,1, 0,12'o4024,4,0,0,10'h000);
    tbl[13] = r(10'h000, 1,0,0,0,0, 0,12'o4024,4,0,1,10'h000);
    tbl[14] = r(10'h002, 0,0,0,0,0, 0,12'o4024,4,0,1,10'h002);
    tbl[15] = r(10'h000, 0,0,0,0,0, 0,12'o4024,4,0,1,10'h002);
    tbl[16] = r(10'h000, 0,1,0,0,0, 0,12'o4024,4,0,0,10'h002);
    tbl[17] = r(10'h000, 0,0,0,0,0, 1,12'o4010,1,0,0,10'h002);
    tbl[18] = r(10'h000, 0,0,0,1,0, 0,12'o4010,1,1,0,10'h000);
    tbl[19] = r(10'h000, 0,0,0,0,1, 0,12'o4010,1,0,0,10'h000);
    tbl[20] = r(10'h008, 0,0,0,0,0, 0,12'o4010,1,0,0,10'h008);
    tbl[21] = r(10'h000, 0,0,0,0,0, 1,12'o4020,3,0,0,10'h008);
    tbl[22] = r(10'h000, 0,0,1,0,0, 0,12'o4020,3,0,0,10'h008);
    tbl[23] = r(10'h000, 0,0,1,0,1, 0,12'o4020,3,0,0,10'h008);
    tbl[24] = r(10'h000, 0,0,0,0,0, 1,12'o4020,3,0,0,10'h008);
    tbl[25] = r(10'h008, 0,0,0,1,0, 0,12'o4020,3,1,0,10'h008);
    tbl[26] = r(10'h009, 0,0,0,0,0, 0,12'o4020,3,1,0,10'h009);
    tbl[27] = r(10'h000, 0,0,0,0,0, 0,12'o4020,3,1,0,10'h009);
    tbl[28] = r(10'h000, 0,0,0,0,1, 0,12'o4020,3,0,0,10'h009);
    tbl[29] = r(10'h000, 0,0,0,0,0, 1,12'o4004,0,0,0,10'h009);
    tbl[30] = r(10'h000, 0,0,0,1,0, 0,12'o4004,0,1,0,10'h008);
    tbl[31] = r(10'h000, 0,0,0,0,1, 0,12'o4004,0,0,0,10'h008);
    tbl[32] = r(10'h000, 0,0,0,0,0, 1,12'o4020,3,0,0,10'h008);
    tbl[33] = r(10'h000, 0,0,1,1,0, 0,12'o4020,3,1,0,10'h000);
    tbl[34] = r(10'h000, 1,1,0,0,1, 0,12'o4020,3,0,1,10'h000);
    tbl[35] = r(10'h000, 0,1,0,1,0, 0,12'o4020,3,0,0,10'h000);
    do_reset();
    #1;
    check("reset_state", '0);
    foreach (tbl[k]) begin
      drive(tbl[k].src, tbl[k].set, tbl[k].clr, tbl[k].ovf, tbl[k].ack, tbl[k].res);
      cycle();
      check($sformatf("table%0d", k), {tbl[k].req, tbl[k].vec, tbl[k].idx, tbl[k].isr, tbl[k].inh, tbl[k].pend});
    end
    do_reset();
    drive(10'h020, 0,0,0,0,0); cycle();
    check("rst_seq_pend", {1'b0, 12'o0000, 4'd0, 1'b0, 1'b0, 10'h020});
    drive(10'h000, 0,0,0,0,0); cycle();
    check("rst_seq_req", {1'b1, 12'o4030, 4'd5, 1'b0, 1'b0, 10'h020});
    #3 rst_l = 1'b0;
    #1 check("async_rst_in_req", '0);
    @(negedge clock) rst_l = 1'b1;
    drive(10'h020, 0,0,0,0,0); cycle();
    drive(10'h000, 0,0,0,0,0); cycle();
    drive(10'h000, 0,0,0,1,0); cycle();
    check("rst_seq_isr", {1'b0, 12'o4030, 4'd5, 1'b1, 1'b0, 10'h000});
    #3 rst_l = 1'b0;
    #1 check("async_rst_in_isr", '0);
    drive(10'h040, 0,0,0,0,0);
    @(negedge clock) rst_l = 1'b1;
    cycle();
    check("held_src_event", {1'b0, 12'o0000, 4'd0, 1'b0, 1'b0, 10'h040});
    cycle();
    check("held_src_req", {1'b1, 12'o4034, 4'd6, 1'b0, 1'b0, 10'h040});
    drive(10'h040, 0,0,0,1,0); cycle();
    drive(10'h040, 0,0,0,0,1); cycle();
    drive(10'h040, 0,0,0,0,0); cycle();
    check("held_src_single", {1'b0, 12'o4034, 4'd6, 1'b0, 1'b0, 10'h000});
    do_reset();
    model_reset();
    src = '0; ovf = 0;
    for (int n = 0; n < 3000; n++) begin
      src = src ^ (10'($urandom) & 10'($urandom) & 10'($urandom));
      set = $urandom_range(0, 15) == 0;
      clr = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 15) == 0) ovf = ~ovf;
      ack = $urandom_range(0, 1) == 1;
      res = $urandom_range(0, 3) == 0;
      drive(src, set, clr, ovf, ack, res);
      model_step(src, set, clr, ovf, ack, res);
      cycle();
      check($sformatf("rand%0d", n), {m_req, 12'(m_vec), 4'(m_idx), m_isr, m_inh, m_pend});
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
